// File: rtl/tcu_sched_if.sv
// Handshake/bus bundle between PSU, the timing control unit and QXU.
//  slave  : the scheduler's view (consumes PSU pushes, drives issues and status)
//  master : the environment's view (PSU + downstream consumer)
interface tcu_sched_if #(
  parameter int OPCODE_BW = 4,
  parameter int TIME_BW   = 8,
  parameter int CWD_BW    = 4,
  parameter int NUM_PQ    = 16,
  parameter int ADDR_BW   = 2
);
  logic                     flush;
  logic                     psu_valid;
  logic                     psu_ready;
  logic [OPCODE_BW-1:0]     opcode_in;
  logic [TIME_BW-1:0]       timing_in;
  logic [NUM_PQ*CWD_BW-1:0] cwdarray_in;
  logic                     out_ready;
  logic                     tcu_valid;
  logic [OPCODE_BW-1:0]     opcode_out;
  logic [NUM_PQ*CWD_BW-1:0] cwdarray_out;
  logic                     timebuf_full;
  logic                     timebuf_empty;
  logic [ADDR_BW:0]         num_item;
  logic                     late_flag;

  modport slave (
    input  flush, psu_valid, opcode_in, timing_in, cwdarray_in, out_ready,
    output psu_ready, tcu_valid, opcode_out, cwdarray_out,
           timebuf_full, timebuf_empty, num_item, late_flag
  );

  modport master (
    output flush, psu_valid, opcode_in, timing_in, cwdarray_in, out_ready,
    input  psu_ready, tcu_valid, opcode_out, cwdarray_out,
           timebuf_full, timebuf_empty, num_item, late_flag
  );
endinterface

// File: rtl/tcu_sched_fifo.sv
// Timing control unit: show-ahead FIFO of {opcode, delay, codeword array}
// entries. The head is released when the inter-issue countdown has reached 1
// and the downstream consumer is ready.
//  clk  : clock
//  rst  : asynchronous active-high reset
//  bus  : tcu_sched_if.slave -- PSU push side, QXU issue side, flush,
//         occupancy (num_item/full/empty) and sticky late_flag
module tcu_sched_fifo #(
  parameter int OPCODE_BW = 4,
  parameter int TIME_BW   = 8,
  parameter int CWD_BW    = 4,
  parameter int NUM_PQ    = 16,
  parameter int ADDR_BW   = 2
) (
  input  logic         clk,
  input  logic         rst,
  tcu_sched_if.slave   bus
);
  localparam int DEPTH = 1 << ADDR_BW;

  typedef logic [NUM_PQ-1:0][CWD_BW-1:0] cwd_t;

  logic [OPCODE_BW-1:0] op_mem_q  [DEPTH];
  logic [TIME_BW-1:0]   tm_mem_q  [DEPTH];
  cwd_t                 cwd_mem_q [DEPTH];

  logic [ADDR_BW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_BW:0]   cnt_q, cnt_d;
  logic [TIME_BW-1:0] timer_q, timer_d;
  logic               late_q, late_d;

  logic full, empty, timer_match, push, pop, stall;
  logic [TIME_BW-1:0] head_tm;
  cwd_t               head_cwd;

  assign full        = (cnt_q == (ADDR_BW+1)'(DEPTH));
  assign empty       = (cnt_q == '0);
  assign timer_match = (timer_q == TIME_BW'(1));
  assign head_tm     = tm_mem_q[rd_ptr_q];
  assign head_cwd    = cwd_mem_q[rd_ptr_q];

  // flush masks both sides of the FIFO for the cycle it is asserted
  assign pop   = ~bus.flush & timer_match & ~empty & bus.out_ready;
  assign stall = ~bus.flush & timer_match & ~empty & ~bus.out_ready;
  assign push  = ~bus.flush & bus.psu_valid & ~full;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    timer_d  = timer_q;
    late_d   = late_q | stall;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      timer_d  = TIME_BW'(1);
      late_d   = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
      // load clamps to 1 so the timer can never underflow to 0
      if (pop)               timer_d = (head_tm == '0) ? TIME_BW'(1) : head_tm;
      else if (!timer_match) timer_d = timer_q - 1'b1;
      else                   timer_d = TIME_BW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      timer_q  <= TIME_BW'(1);
      late_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      timer_q  <= timer_d;
      late_q   <= late_d;
    end
  end

  // Storage is not reset; the head is masked while empty instead.
  always_ff @(posedge clk) begin
    if (push) begin
      op_mem_q[wr_ptr_q]  <= bus.opcode_in;
      tm_mem_q[wr_ptr_q]  <= bus.timing_in;
      cwd_mem_q[wr_ptr_q] <= cwd_t'(bus.cwdarray_in);
    end
  end

  assign bus.opcode_out = empty ? '0 : op_mem_q[rd_ptr_q];

  for (genvar l = 0; l < NUM_PQ; l++) begin : g_lane
    assign bus.cwdarray_out[l*CWD_BW +: CWD_BW] = empty ? '0 : head_cwd[l];
  end

  assign bus.tcu_valid     = pop;
  assign bus.psu_ready     = ~full;
  assign bus.timebuf_full  = full;
  assign bus.timebuf_empty = empty;
  assign bus.num_item      = cnt_q;
  assign bus.late_flag     = late_q;
endmodule

// File: tb/tb_tcu_sched_fifo.sv
module tb_tcu_sched_fifo;
  localparam int OBW = 4, TBW = 8, CBW = 4, NPQ = 16, ABW = 2;
  localparam int DEPTH = 1 << ABW;
  localparam int CW = NPQ * CBW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tcu_sched_if #(.OPCODE_BW(OBW), .TIME_BW(TBW), .CWD_BW(CBW), .NUM_PQ(NPQ), .ADDR_BW(ABW)) bus ();

  tcu_sched_fifo #(.OPCODE_BW(OBW), .TIME_BW(TBW), .CWD_BW(CBW), .NUM_PQ(NPQ), .ADDR_BW(ABW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic f, input logic pv, input logic [OBW-1:0] op,
                        input logic [TBW-1:0] tm, input logic [CW-1:0] cwd, input logic ordy);
    bus.flush = f; bus.psu_valid = pv; bus.opcode_in = op;
    bus.timing_in = tm; bus.cwdarray_in = cwd; bus.out_ready = ordy;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"}, bus.tcu_valid, 0);
    chk({tag, "_ready"}, bus.psu_ready, 1);
    chk({tag, "_empty"}, bus.timebuf_empty, 1);
    chk({tag, "_full"},  bus.timebuf_full, 0);
    chk({tag, "_num"},   bus.num_item, 0);
    chk({tag, "_late"},  bus.late_flag, 0);
    chk({tag, "_op"},    bus.opcode_out, 0);
    chk({tag, "_cwd"},   bus.cwdarray_out, 0);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic           pv;
    logic [OBW-1:0] op;
    logic [TBW-1:0] tm;
    logic           ordy;
    logic           e_vld;
    logic [OBW-1:0] e_op;
    int             e_num;
  } vec_t;

  vec_t vt[12];

  function automatic vec_t mk(logic pv, logic [OBW-1:0] op, logic [TBW-1:0] tm, logic ordy,
                              logic ev, logic [OBW-1:0] eop, int en);
    vec_t v;
    v.pv = pv; v.op = op; v.tm = tm; v.ordy = ordy; v.e_vld = ev; v.e_op = eop; v.e_num = en;
    return v;
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    logic [OBW-1:0] op;
    logic [TBW-1:0] tm;
    logic [CW-1:0]  cwd;
  } ent_t;

  ent_t q[$];
  int   cyc = 0;
  int   earliest = 0;   // first cycle at which the next issue is allowed
  logic m_late = 1'b0;

  task automatic mstep(input string tag, input logic f, input logic pv, input logic [OBW-1:0] op,
                       input logic [TBW-1:0] tm, input logic [CW-1:0] cwd, input logic ordy);
    int   sz;
    logic ev;
    ent_t e;
    set_in(f, pv, op, tm, cwd, ordy);
    #1;
    sz = q.size();
    ev = !f && sz > 0 && cyc >= earliest && ordy;
    chk({tag, "_valid"}, bus.tcu_valid, ev);
    chk({tag, "_num"},   bus.num_item, sz);
    chk({tag, "_empty"}, bus.timebuf_empty, sz == 0);
    chk({tag, "_full"},  bus.timebuf_full, sz == DEPTH);
    chk({tag, "_ready"}, bus.psu_ready, sz != DEPTH);
    chk({tag, "_late"},  bus.late_flag, m_late);
    if (ev) begin
      chk({tag, "_op"},  bus.opcode_out, q[0].op);
      chk({tag, "_cwd"}, bus.cwdarray_out, q[0].cwd);
    end
    if (f) begin
      q.delete();
      earliest = cyc + 1;
      m_late = 1'b0;
    end else begin
      if (sz > 0 && cyc >= earliest && !ordy) m_late = 1'b1;
      if (ev) begin
        earliest = cyc + ((q[0].tm == 0) ? 1 : int'(q[0].tm));
        void'(q.pop_front());
      end
      if (pv && sz < DEPTH) begin
        e.op = op; e.tm = tm; e.cwd = cwd;
        q.push_back(e);
      end
    end
    @(posedge clk); cyc++; @(negedge clk);
  endtask

  task automatic idle(input string tag, input int n, input logic ordy);
    for (int k = 0; k < n; k++) mstep(tag, 0, 0, 0, 0, 0, ordy);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    chk_reset_vals(tag);
    q.delete(); m_late = 1'b0; earliest = 0;
    @(posedge clk); cyc++; @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [CW-1:0] rcwd();
    return {$urandom, $urandom};
  endfunction

  initial begin
    // test 1: three back-to-back issues; test 2: timing=4 spacing
    vt[0]  = mk(1, 4'h1, 1, 1, 0, 0,    0);
    vt[1]  = mk(1, 4'h2, 1, 1, 1, 4'h1, 1);
    vt[2]  = mk(1, 4'h3, 1, 1, 1, 4'h2, 1);
    vt[3]  = mk(0, 0,    0, 1, 1, 4'h3, 1);
    vt[4]  = mk(0, 0,    0, 1, 0, 0,    0);
    vt[5]  = mk(1, 4'hA, 4, 1, 0, 0,    0);
    vt[6]  = mk(1, 4'hB, 1, 1, 1, 4'hA, 1);
    vt[7]  = mk(0, 0,    0, 1, 0, 0,    1);
    vt[8]  = mk(0, 0,    0, 1, 0, 0,    1);
    vt[9]  = mk(0, 0,    0, 1, 0, 0,    1);
    vt[10] = mk(0, 0,    0, 1, 1, 4'hB, 1);
    vt[11] = mk(0, 0,    0, 1, 0, 0,    0);

    set_in(0, 0, 0, 0, 0, 0);
    #1;
    chk_reset_vals("por");
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      set_in(0, vt[i].pv, vt[i].op, vt[i].tm, {16{4'h5}}, vt[i].ordy);
      #1;
      chk($sformatf("tab%0d_valid", i), bus.tcu_valid, vt[i].e_vld);
      if (vt[i].e_vld) chk($sformatf("tab%0d_op", i), bus.opcode_out, vt[i].e_op);
      chk($sformatf("tab%0d_num", i), bus.num_item, vt[i].e_num);
      chk($sformatf("tab%0d_empty", i), bus.timebuf_empty, vt[i].e_num == 0);
      chk($sformatf("tab%0d_late", i), bus.late_flag, 0);
      @(negedge clk);
    end

    do_reset("rst1");

    // test 3: fill with out_ready=0, 5th push dropped, then drain
    for (int i = 0; i < 5; i++) mstep("fill", 0, 1, OBW'(i + 3), 1, rcwd(), 0);
    #1;
    chk("fill_num4", bus.num_item, 4);
    chk("fill_ready0", bus.psu_ready, 0);
    idle("drain", 6, 1);
    mstep("fl0", 1, 0, 0, 0, 0, 1);

    // test 4: head due, out_ready low for 3 cycles, then released
    mstep("st_push", 0, 1, 4'h7, 3, rcwd(), 0);
    idle("stall", 3, 0);
    #1;
    chk("stall_late", bus.late_flag, 1);
    idle("release", 3, 1);

    // test 5: flush with 2 queued and timer reloaded with 5
    mstep("f_a", 0, 1, 4'h1, 5, rcwd(), 1);
    mstep("f_b", 0, 1, 4'h2, 1, rcwd(), 1);
    mstep("f_c", 0, 1, 4'h3, 1, rcwd(), 1);
    mstep("f_flush", 1, 1, 4'h4, 1, rcwd(), 1);
    #1;
    chk("flush_num", bus.num_item, 0);
    chk("flush_late", bus.late_flag, 0);
    chk("flush_valid", bus.tcu_valid, 0);
    mstep("f_after", 0, 1, 4'h9, 2, rcwd(), 1);
    idle("f_idle", 3, 1);

    // test 6: timing 0 acts as 1; reset mid-countdown
    mstep("z_a", 0, 1, 4'hC, 0, rcwd(), 1);
    mstep("z_b", 0, 1, 4'hD, 9, rcwd(), 1);
    mstep("z_c", 0, 1, 4'hE, 1, rcwd(), 1);
    idle("z_cnt", 3, 1);
    do_reset("rst_mid");

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      mstep($sformatf("rnd%0d", i),
            ($urandom_range(0, 99) < 3),
            ($urandom_range(0, 99) < 60),
            OBW'($urandom),
            TBW'($urandom_range(0, 5)),
            rcwd(),
            ($urandom_range(0, 99) < 75));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
